// File: rtl/ahb_slv_mem.sv
// AHB slave holding a 2^(ADDR_W-2) x 32-bit little-endian memory behind one HSEL.
// Latency: data phase follows the address phase by one cycle; OKAY transfers add WAIT_CYC waits.
// Backpressure: HREADYOUT low during wait states and ERR1; new transfers are accepted only when HREADY is high.
//
// Ports:
//   HCLK, HRST          clock and synchronous active-high reset
//   HSEL, HADDR, HSIZE, HWRITE, HTRANS, HBURST, HPROT
//                       address-phase controls (HBURST/HPROT are ignored)
//   HWDATA              write data, sampled on the edge ending the last data-phase cycle
//   HREADY              global bus ready (gates accept)
//   HREADYOUT, HRESP    registered slave response (OKAY=00, ERROR=01)
//   HRDATA              read data during a read data phase, zero otherwise
//   HSPLIT              tied to zero; this slave never splits
module ahb_slv_mem #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 1
) (
    input  logic        HCLK,
    input  logic        HRST,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA,
    output logic [15:0] HSPLIT
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic                hreadyout_q, hreadyout_d;
    logic [1:0]          hresp_q, hresp_d;

    logic [31:0]         mem [DEPTH];

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic                accept;      // a real transfer is on the bus for us
    logic                final_beat;  // last cycle of an OKAY data phase
    logic                can_take;    // FSM is in a cycle where HREADYOUT is high
    logic                take;
    logic                addr_err;

    assign accept     = HSEL & HREADY & HTRANS[1];
    assign final_beat = (state_q == ST_DATA) && (wcnt_q == 4'd0);
    assign can_take   = (state_q == ST_IDLE) || final_beat || (state_q == ST_ERR2);
    assign take       = accept & can_take;

    // Sizes above a word, and misaligned halfwords/words, get ERROR.
    assign addr_err = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_DATA: begin
                if (wcnt_q != 4'd0) begin
                    state_d = ST_DATA;
                    wcnt_d  = wcnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A new address phase overrides the fall-back to IDLE, which gives
        // pipelined back-to-back transfers with no bubble.
        if (take) begin
            addr_d  = HADDR[ADDR_W-1:0];
            size_d  = HSIZE;
            write_d = HWRITE;
            err_d   = addr_err;
            if (addr_err) begin
                state_d = ST_ERR1;
                wcnt_d  = 4'd0;
            end else begin
                state_d = ST_DATA;
                wcnt_d  = 4'(WAIT_CYC);
            end
        end
    end

    // Outputs are a function of the next state so they come straight from flops.
    always_comb begin
        hreadyout_d = 1'b1;
        hresp_d     = RESP_OKAY;
        case (state_d)
            ST_IDLE: begin
                hreadyout_d = 1'b1;
                hresp_d     = RESP_OKAY;
            end
            ST_DATA: begin
                hreadyout_d = (wcnt_d == 4'd0);
                hresp_d     = RESP_OKAY;
            end
            ST_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = RESP_ERROR;
            end
            ST_ERR2: begin
                hreadyout_d = 1'b1;
                hresp_d     = RESP_ERROR;
            end
            default: begin
                hreadyout_d = 1'b1;
                hresp_d     = RESP_OKAY;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRST) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 4'd0;
            addr_q      <= '0;
            size_q      <= 3'd0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            write_q     <= write_d;
            err_q       <= err_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory write: committed on the edge that ends the final data cycle.
    // Reset on that same edge discards the write.
    // ------------------------------------------------------------------
    logic [ADDR_W-3:0] widx;
    logic [3:0]        byte_en;
    logic              commit;

    assign widx   = addr_q[ADDR_W-1:2];
    assign commit = final_beat & write_q & ~HRST;

    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            3'd0:    byte_en = 4'b0001 << addr_q[1:0];
            3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // No reset on the array: contents survive HRST.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[widx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Read data is driven for the whole read data phase; a preceding write
    // has always committed before this phase starts, so no forwarding.
    assign HRDATA    = ((state_q == ST_DATA) && !write_q && !err_q) ? mem[widx] : 32'h0;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HSPLIT    = 16'h0000;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HADDR[31:ADDR_W], HTRANS[0]};

endmodule

// File: tb/tb_ahb_slv_mem.sv
// Directed bench for ahb_slv_mem: a WAIT_CYC=1 instance driven from a vector table,
// a WAIT_CYC=0 instance for pipelined write/read, plus reset-abort sequences.
// Each slave is alone on its bus, so its HREADY is its own HREADYOUT.
module tb_ahb_slv_mem;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRST;
    logic        hsel_a, hsel_b;
    logic [31:0] HADDR;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;

    logic        rdy_a, rdy_b;
    logic [1:0]  resp_a, resp_b;
    logic [31:0] rdata_a, rdata_b;
    logic [15:0] split_a, split_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 HCLK = ~HCLK;

    ahb_slv_mem #(.ADDR_W(10), .WAIT_CYC(1)) u_a (
        .HCLK(HCLK), .HRST(HRST), .HSEL(hsel_a), .HADDR(HADDR), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HBURST(HBURST), .HPROT(HPROT),
        .HWDATA(HWDATA), .HREADY(rdy_a), .HREADYOUT(rdy_a), .HRESP(resp_a),
        .HRDATA(rdata_a), .HSPLIT(split_a)
    );

    ahb_slv_mem #(.ADDR_W(10), .WAIT_CYC(0)) u_b (
        .HCLK(HCLK), .HRST(HRST), .HSEL(hsel_b), .HADDR(HADDR), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HBURST(HBURST), .HPROT(HPROT),
        .HWDATA(HWDATA), .HREADY(rdy_b), .HREADYOUT(rdy_b), .HRESP(resp_b),
        .HRDATA(rdata_b), .HSPLIT(split_b)
    );

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [1:0]  trans;
        logic [31:0] wdata;
        logic        exp_rdy;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic sel, input logic [31:0] addr, input logic [2:0] size,
                                input logic wr, input logic [1:0] trans, input logic [31:0] wdata,
                                input logic rdy, input logic [1:0] resp, input logic [31:0] rdata);
        vec_t v;
        v.sel = sel; v.addr = addr; v.size = size; v.wr = wr; v.trans = trans;
        v.wdata = wdata; v.exp_rdy = rdy; v.exp_resp = resp; v.exp_rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drv(input logic sa, input logic sb, input logic [31:0] addr, input logic [2:0] size,
                       input logic wr, input logic [1:0] trans, input logic [31:0] wdata, input logic rst);
        hsel_a = sa; hsel_b = sb; HADDR = addr; HSIZE = size;
        HWRITE = wr; HTRANS = trans; HWDATA = wdata; HRST = rst;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic rdy, input logic [1:0] resp, input logic [31:0] rd);
        chk({tag, " a.rdy"},   {31'h0, rdy_a},  {31'h0, rdy});
        chk({tag, " a.resp"},  {30'h0, resp_a}, {30'h0, resp});
        chk({tag, " a.rdata"}, rdata_a, rd);
    endtask

    task automatic chk_b(input string tag, input logic rdy, input logic [1:0] resp, input logic [31:0] rd);
        chk({tag, " b.rdy"},   {31'h0, rdy_b},  {31'h0, rdy});
        chk({tag, " b.resp"},  {30'h0, resp_b}, {30'h0, resp});
        chk({tag, " b.rdata"}, rdata_b, rd);
    endtask

    initial begin
        HBURST = 3'b000;
        HPROT  = 4'b0011;
        drv(0, 0, 32'h0, 3'd0, 0, T_IDLE, 32'h0, 1);
        tick();
        tick();
        drv(0, 0, 32'h0, 3'd0, 0, T_IDLE, 32'h0, 0);

        // Reset state held on an idle bus.
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            chk_a($sformatf("idle%0d", i), 1'b1, 2'b00, 32'h0);
            chk_b($sformatf("idle%0d", i), 1'b1, 2'b00, 32'h0);
            chk($sformatf("idle%0d split", i), {split_a, split_b}, 32'h0);
            tick();
        end

        // WAIT_CYC=1 vectors: inputs and expected outputs of the same cycle.
        //          sel addr      sz wr trans   wdata         rdy resp  rdata
        tbl.push_back(mk(1, 32'h010, 2, 1, T_NSEQ, 32'h0,        1, 2'b00, 32'h0));        // word write addr
        tbl.push_back(mk(0, 32'h000, 0, 0, T_IDLE, 32'hDEADBEEF, 0, 2'b00, 32'h0));        // wait
        tbl.push_back(mk(1, 32'h010, 2, 0, T_NSEQ, 32'hDEADBEEF, 1, 2'b00, 32'h0));        // commit + read addr
        tbl.push_back(mk(0, 32'h000, 0, 0, T_IDLE, 32'h0,        0, 2'b00, 32'hDEADBEEF));
        tbl.push_back(mk(1, 32'h013, 0, 1, T_NSEQ, 32'h0,        1, 2'b00, 32'hDEADBEEF)); // byte write addr
        tbl.push_back(mk(0, 32'h000, 0, 0, T_IDLE, 32'hAA000000, 0, 2'b00, 32'h0));
        tbl.push_back(mk(1, 32'h010, 1, 1, T_NSEQ, 32'hAA000000, 1, 2'b00, 32'h0));        // halfword write addr
        tbl.push_back(mk(0, 32'h000, 0, 0, T_IDLE, 32'h00005566, 0, 2'b00, 32'h0));
        tbl.push_back(mk(1, 32'h010, 2, 0, T_NSEQ, 32'h00005566, 1, 2'b00, 32'h0));        // read addr
        tbl.push_back(mk(0, 32'h000, 0, 0, T_IDLE, 32'h0,        0, 2'b00, 32'hAAAD5566));
        tbl.push_back(mk(1, 32'h011, 1, 1, T_NSEQ, 32'h0,        1, 2'b00, 32'hAAAD5566)); // misaligned halfword
        tbl.push_back(mk(0, 32'h000, 0, 0, T_IDLE, 32'h12345678, 0, 2'b01, 32'h0));        // ERR1
        tbl.push_back(mk(1, 32'h010, 3, 1, T_NSEQ, 32'h12345678, 1, 2'b01, 32'h0));        // ERR2 + size 3 write
        tbl.push_back(mk(0, 32'h000, 0, 0, T_IDLE, 32'h87654321, 0, 2'b01, 32'h0));        // ERR1
        tbl.push_back(mk(1, 32'h010, 2, 0, T_NSEQ, 32'h87654321, 1, 2'b01, 32'h0));        // ERR2 + read addr
        tbl.push_back(mk(0, 32'h000, 0, 0, T_IDLE, 32'h0,        0, 2'b00, 32'hAAAD5566)); // unchanged
        tbl.push_back(mk(1, 32'h010, 2, 1, T_BUSY, 32'h0,        1, 2'b00, 32'hAAAD5566)); // BUSY: ignored
        tbl.push_back(mk(0, 32'h010, 2, 1, T_NSEQ, 32'hFFFFFFFF, 1, 2'b00, 32'h0));        // not selected
        tbl.push_back(mk(1, 32'h010, 2, 0, T_NSEQ, 32'hFFFFFFFF, 1, 2'b00, 32'h0));        // read addr
        tbl.push_back(mk(0, 32'h000, 0, 0, T_IDLE, 32'h0,        0, 2'b00, 32'hAAAD5566)); // HSEL drops mid-phase
        tbl.push_back(mk(1, 32'h010, 2, 1, T_IDLE, 32'h0,        1, 2'b00, 32'hAAAD5566)); // selected IDLE
        tbl.push_back(mk(0, 32'h000, 0, 0, T_IDLE, 32'h0,        1, 2'b00, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].sel, 0, tbl[i].addr, tbl[i].size, tbl[i].wr, tbl[i].trans, tbl[i].wdata, 0);
            @(negedge HCLK);
            chk_a($sformatf("row%0d", i), tbl[i].exp_rdy, tbl[i].exp_resp, tbl[i].exp_rdata);
            tick();
        end

        // WAIT_CYC=0: NONSEQ write then SEQ read to the same word on consecutive cycles.
        drv(0, 1, 32'h020, 3'd2, 1, T_NSEQ, 32'h0, 0);
        @(negedge HCLK); chk_b("p0 addr", 1'b1, 2'b00, 32'h0); tick();
        drv(0, 1, 32'h020, 3'd2, 0, T_SEQ, 32'hCAFEF00D, 0);
        @(negedge HCLK); chk_b("p0 wdata", 1'b1, 2'b00, 32'h0); tick();
        drv(0, 0, 32'h0, 3'd0, 0, T_IDLE, 32'h0, 0);
        @(negedge HCLK); chk_b("p0 rdata", 1'b1, 2'b00, 32'hCAFEF00D); tick();
        @(negedge HCLK); chk_b("p0 idle", 1'b1, 2'b00, 32'h0); tick();

        // WAIT_CYC=0: reset during the only data cycle discards the write.
        drv(0, 1, 32'h020, 3'd2, 1, T_NSEQ, 32'h0, 0);
        tick();
        drv(0, 0, 32'h0, 3'd0, 0, T_IDLE, 32'h77777777, 1);
        tick();
        drv(0, 1, 32'h020, 3'd2, 0, T_NSEQ, 32'h0, 0);
        @(negedge HCLK); chk_b("r0 post", 1'b1, 2'b00, 32'h0); tick();
        drv(0, 0, 32'h0, 3'd0, 0, T_IDLE, 32'h0, 0);
        @(negedge HCLK); chk_b("r0 read", 1'b1, 2'b00, 32'hCAFEF00D); tick();

        // WAIT_CYC=1: reset in the wait state of a write aborts it.
        drv(1, 0, 32'h010, 3'd2, 1, T_NSEQ, 32'h0, 0);
        tick();
        drv(0, 0, 32'h0, 3'd0, 0, T_IDLE, 32'h11111111, 1);
        @(negedge HCLK); chk_a("r1 wait", 1'b0, 2'b00, 32'h0); tick();
        drv(1, 0, 32'h010, 3'd2, 0, T_NSEQ, 32'h11111111, 0);
        @(negedge HCLK); chk_a("r1 post", 1'b1, 2'b00, 32'h0); tick();
        drv(0, 0, 32'h0, 3'd0, 0, T_IDLE, 32'h0, 0);
        @(negedge HCLK); chk_a("r1 rd0", 1'b0, 2'b00, 32'hAAAD5566); tick();
        @(negedge HCLK); chk_a("r1 rd1", 1'b1, 2'b00, 32'hAAAD5566); tick();
        @(negedge HCLK); chk_a("r1 idle", 1'b1, 2'b00, 32'h0); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_slv_mem.md
# ahb_slv_mem

AHB slave responder holding a 2^(ADDR_W-2) × 32-bit little-endian register memory, placed behind one HSEL output of the AHB interconnect. It samples address-phase controls, returns data-phase responses with a configurable number of wait states, and signals ERROR for unsupported accesses using the two-cycle response. It never issues RETRY or SPLIT.

## Interface
- ADDR_W, 10, byte-address bits decoded (memory depth = 2^(ADDR_W-2) words, 4 ≤ ADDR_W ≤ 16)
- WAIT_CYC, 1, wait states inserted per OKAY transfer (0..15)
- HCLK  in  1  clock; everything rises on posedge
- HRST  in  1  reset; synchronous and active-high
- HSEL  in  1  slave select from the decoder
- HADDR  in  32  address; only [ADDR_W-1:0] is used
- HSIZE  in  3  transfer size
- HWRITE  in  1  1 = write
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HBURST  in  3  accepted and ignored (every beat carries its own address)
- HPROT  in  4  accepted and ignored
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  global bus ready from the mux
- HREADYOUT  out  1  this slave's ready
- HRESP  out  2  OKAY=00, ERROR=01
- HRDATA  out  32  read data
- HSPLIT  out  16  constant 0

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1] at a posedge. IDLE and BUSY transfers get a zero-wait OKAY with no side effect.
- On accept, the block registers addr_q = HADDR[ADDR_W-1:0], size_q, write_q and err_q.
- err_q = (HSIZE > 2) | (HSIZE==1 & HADDR[0]) | (HSIZE==2 & HADDR[1:0]!=0).
- FSM states IDLE, DATA, ERR1, ERR2, with a 4-bit wait counter wcnt.
  - IDLE: HREADYOUT=1, HRESP=OKAY. On accept: go to ERR1 if err_q, otherwise go to DATA with wcnt=WAIT_CYC.
  - DATA: HREADYOUT = (wcnt==0), HRESP=OKAY. While wcnt≠0, wcnt decrements each cycle. On the final cycle (wcnt==0), the next state follows the IDLE accept rule; with no accept, return to IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR, then go to ERR2 unconditionally.
  - ERR2: HREADYOUT=1, HRESP=ERROR. Next state follows the IDLE accept rule.
- Write commit happens at the posedge ending the final DATA cycle, using HWDATA sampled then. Byte lanes:
  - size 0: lane addr_q[1:0]
  - size 1: lanes [3:2] if addr_q[1], else [1:0]
  - size 2: all four lanes
  - Unselected lanes are unchanged.
- Read: HRDATA = mem[addr_q[ADDR_W-1:2]] (full word) during DATA when write_q=0. HRDATA=0 in all other states. A read's data phase follows any earlier write's commit edge, so it always returns the updated word.
- Errored transfers do not modify memory. HRDATA=0 during ERR1 and ERR2.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, wcnt=0, HREADYOUT=1, HRESP=OKAY, HRDATA=0, HSPLIT=0.
- HRST asserted mid-transfer aborts it: the pending write is discarded, and the outputs take their reset values the cycle after.
- Transfer latency: address phase in cycle N; data phase spans N+1 .. N+1+WAIT_CYC. HREADYOUT is low for WAIT_CYC cycles, then high for 1 cycle.
- Back-to-back transfers: a new accept in the final DATA or ERR2 cycle chains with no IDLE bubble (pipelined address/data).
- While HREADYOUT=0, HREADY is low on the bus, so no new accept can occur. The slave also gates accept on HREADY itself.
- HSEL falling during a data phase does not abort it; the data phase completes normally.
- wcnt is 4 bits wide. WAIT_CYC=0 gives HREADYOUT=1 in every DATA cycle.

## Test plan
- Reset, then idle bus → HREADYOUT=1, HRESP=00 and HRDATA=0 held for 10 cycles.
- WAIT_CYC=1: word write 0xDEADBEEF to 0x010, then word read 0x010 → each data phase shows HREADYOUT 0 then 1; read returns 0xDEADBEEF.
- Byte write 0xAA at 0x013, then halfword write 0x5566 at 0x010, then word read 0x010 → 0xAAxx5566 with byte [23:16] preserved from the prior value.
- Halfword write at 0x011, or HSIZE=3 → ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01); a word read of the target word shows no change.
- WAIT_CYC=0: NONSEQ write followed by SEQ read to the same address on consecutive cycles → no wait states, and the read returns the just-written data.
- Assert HRST in the middle of a write's wait state → HREADYOUT=1 and HRESP=00 next cycle; a later read shows the old word.
